// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, packed read ports and the
// busy-scoreboard mark/count signals. The master drives requests, the
// slave (the register file) returns read data, busy flags and the count.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
);
  logic                     we0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa0;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd0;
  logic [DATA_W-1:0]        wd1;
  logic [N_RD*ADDR_W-1:0]   ra;
  logic [N_RD*DATA_W-1:0]   rd;
  logic [N_RD-1:0]          rbusy;
  logic                     mark_v;
  logic [ADDR_W-1:0]        mark_a;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output we0, we1, wa0, wa1, wd0, wd1, ra, mark_v, mark_a,
    input  rd, rbusy, busy_cnt
  );

  modport slave (
    input  we0, we1, wa0, wa1, wd0, wd1, ra, mark_v, mark_a,
    output rd, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with two write ports, N_RD combinational read
// ports, optional hardwired zero entry, optional same-cycle write forwarding
// and a per-entry busy scoreboard with a registered population count.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_mp_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // Storage, scoreboard and count state
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [ADDR_W:0]   busy_cnt_r;

  // Qualified requests (entry-0 traffic dropped when it is hardwired)
  logic              eff_we0_s;
  logic              eff_we1_s;
  logic              eff_mark_s;

  // Next-state scoreboard and count
  logic [DEPTH-1:0]  busy_nxt_s;
  logic [ADDR_W:0]   cnt_nxt_s;
  logic              inc_s;
  logic              dec0_s;
  logic              dec1_s;

  // Read path working signals
  logic [N_RD*DATA_W-1:0] rd_s;
  logic [N_RD-1:0]        rbusy_s;
  logic [ADDR_W-1:0]      ra_k_s;
  logic                   hit0_s;
  logic                   hit1_s;
  logic                   mark_hit_s;
  logic [DATA_W-1:0]      val_s;

  // Drop writes and marks aimed at the hardwired zero entry
  always_comb begin
    eff_we0_s  = bus.we0;
    eff_we1_s  = bus.we1;
    eff_mark_s = bus.mark_v;
    if (ZERO_EN) begin
      eff_we0_s  = bus.we0    && (bus.wa0    != ADDR_ZERO);
      eff_we1_s  = bus.we1    && (bus.wa1    != ADDR_ZERO);
      eff_mark_s = bus.mark_v && (bus.mark_a != ADDR_ZERO);
    end else begin
      eff_we0_s  = bus.we0;
      eff_we1_s  = bus.we1;
      eff_mark_s = bus.mark_v;
    end
  end

  // Commit writes on the edge; port 1 wins when both target one entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (eff_we1_s && (bus.wa1 == ADDR_W'(i))) begin
          mem_r[i] <= bus.wd1;
        end else if (eff_we0_s && (bus.wa0 == ADDR_W'(i))) begin
          mem_r[i] <= bus.wd0;
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

  // Scoreboard next state: writes clear, a mark sets and overrides a clear
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (eff_mark_s && (bus.mark_a == ADDR_W'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if ((eff_we0_s && (bus.wa0 == ADDR_W'(i))) ||
                   (eff_we1_s && (bus.wa1 == ADDR_W'(i)))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Incremental population count: +1 for a fresh mark, -1 per distinct
  // written entry that was busy and is not re-marked this cycle
  always_comb begin
    inc_s  = eff_mark_s && !busy_r[bus.mark_a];
    dec0_s = eff_we0_s && busy_r[bus.wa0] &&
             !(eff_mark_s && (bus.mark_a == bus.wa0));
    dec1_s = eff_we1_s && busy_r[bus.wa1] &&
             !(eff_mark_s && (bus.mark_a == bus.wa1)) &&
             !(eff_we0_s && (bus.wa0 == bus.wa1));
    cnt_nxt_s = busy_cnt_r;
    if (inc_s) begin
      cnt_nxt_s = cnt_nxt_s + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
    if (dec0_s) begin
      cnt_nxt_s = cnt_nxt_s - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
    if (dec1_s) begin
      cnt_nxt_s = cnt_nxt_s - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // Scoreboard bits and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= {DEPTH{1'b0}};
      busy_cnt_r <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= cnt_nxt_s;
    end
  end

  // Combinational read ports with forwarding and busy reporting
  always_comb begin
    rd_s       = {(N_RD*DATA_W){1'b0}};
    rbusy_s    = {N_RD{1'b0}};
    ra_k_s     = ADDR_ZERO;
    hit0_s     = 1'b0;
    hit1_s     = 1'b0;
    mark_hit_s = 1'b0;
    val_s      = {DATA_W{1'b0}};
    for (int k = 0; k < N_RD; k++) begin
      ra_k_s     = bus.ra[k*ADDR_W +: ADDR_W];
      hit0_s     = BYP_EN && eff_we0_s && (bus.wa0 == ra_k_s);
      hit1_s     = BYP_EN && eff_we1_s && (bus.wa1 == ra_k_s);
      mark_hit_s = eff_mark_s && (bus.mark_a == ra_k_s);
      if (!rst_n) begin
        val_s = {DATA_W{1'b0}};
      end else if (ZERO_EN && (ra_k_s == ADDR_ZERO)) begin
        val_s = {DATA_W{1'b0}};
      end else if (hit1_s) begin
        val_s = bus.wd1;
      end else if (hit0_s) begin
        val_s = bus.wd0;
      end else begin
        val_s = mem_r[ra_k_s];
      end
      rd_s[k*DATA_W +: DATA_W] = val_s;
      if (!rst_n) begin
        rbusy_s[k] = 1'b0;
      end else if ((hit0_s || hit1_s) && !mark_hit_s) begin
        rbusy_s[k] = 1'b0;
      end else begin
        rbusy_s[k] = busy_r[ra_k_s];
      end
    end
  end

  assign bus.rd       = rd_s;
  assign bus.rbusy    = rbusy_s;
  assign bus.busy_cnt = busy_cnt_r;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a forwarding instance and a
// non-forwarding instance share stimulus; an array model tracks contents
// and busy bits, and directed sequences pin literal expectations.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   chk_en;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) bus ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) bus_nb ();

  assign bus_nb.we0    = bus.we0;
  assign bus_nb.we1    = bus.we1;
  assign bus_nb.wa0    = bus.wa0;
  assign bus_nb.wa1    = bus.wa1;
  assign bus_nb.wd0    = bus.wd0;
  assign bus_nb.wd1    = bus.wd1;
  assign bus_nb.ra     = bus.ra;
  assign bus_nb.mark_v = bus.mark_v;
  assign bus_nb.mark_a = bus.mark_a;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(0))
    dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents, busy set and its size
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  int            m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Asynchronous reset empties the model immediately
  always @(negedge rst_n) begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
  end

  // Apply the edge's writes and mark to the model
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.we0 && bus.wa0 != 0) begin
        m_mem[bus.wa0]  = bus.wd0;
        m_busy[bus.wa0] = 1'b0;
      end
      if (bus.we1 && bus.wa1 != 0) begin
        m_mem[bus.wa1]  = bus.wd1;
        m_busy[bus.wa1] = 1'b0;
      end
      if (bus.mark_v && bus.mark_a != 0) m_busy[bus.mark_a] = 1'b1;
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_cnt += int'(m_busy[i]);
    end
  end

  function automatic logic [DW-1:0] exp_rd(input int k, input bit byp);
    logic [AW-1:0] a;
    a = bus.ra[k*AW +: AW];
    if (!rst_n || a == 0) return '0;
    if (byp && bus.we1 && bus.wa1 == a) return bus.wd1;
    if (byp && bus.we0 && bus.wa0 == a) return bus.wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rbusy(input int k, input bit byp);
    logic [AW-1:0] a;
    bit fwd;
    a = bus.ra[k*AW +: AW];
    if (!rst_n || a == 0) return 1'b0;
    fwd = byp && ((bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a));
    if (fwd && !(bus.mark_v && bus.mark_a == a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        check($sformatf("rd%0d", k), 64'(bus.rd[k*DW +: DW]), 64'(exp_rd(k, 1'b1)));
        check($sformatf("rbusy%0d", k), 64'(bus.rbusy[k]), 64'(exp_rbusy(k, 1'b1)));
        check($sformatf("nb_rd%0d", k), 64'(bus_nb.rd[k*DW +: DW]), 64'(exp_rd(k, 1'b0)));
        check($sformatf("nb_rbusy%0d", k), 64'(bus_nb.rbusy[k]), 64'(exp_rbusy(k, 1'b0)));
      end
      check("busy_cnt", 64'(bus.busy_cnt), 64'(m_cnt));
      check("nb_busy_cnt", 64'(bus_nb.busy_cnt), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.we1 = 1'b0; bus.mark_v = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we0 = 1'b1; bus.wa0 = a; bus.wd0 = d;
  endtask

  task automatic mark(input logic [AW-1:0] a);
    bus.mark_v = 1'b1; bus.mark_a = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    checks = 0; errors = 0; chk_en = 1'b0;
    rst_n = 1'b1;
    bus.we0 = 1'b0; bus.we1 = 1'b0; bus.wa0 = '0; bus.wa1 = '0;
    bus.wd0 = '0; bus.wd1 = '0; bus.ra = '0; bus.mark_v = 1'b0; bus.mark_a = '0;
    #3 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check("reset_rd0", 64'(bus.rd[DW-1:0]), 64'h0);
    check("reset_cnt", 64'(bus.busy_cnt), 64'h0);
    step(); step();
    #2 rst_n = 1'b1;

    // Sequential writes then two-port reads
    step(); wr0(5'd1, 32'd1);
    step(); wr0(5'd2, 32'd2);
    step(); wr0(5'd3, 32'd3);
    step(); idle(); bus.ra = {5'd3, 5'd1};
    #2 check("seq_rd0", 64'(bus.rd[31:0]), 64'd1);
    check("seq_rd1", 64'(bus.rd[63:32]), 64'd3);
    bus.ra = {5'd0, 5'd2};
    #1 check("seq_rd0b", 64'(bus.rd[31:0]), 64'd2);
    check("seq_rd1b", 64'(bus.rd[63:32]), 64'd0);

    // Dual write to one entry: port 1 wins, forwarded only when enabled
    step(); wr0(5'd5, 32'hAAAA); bus.we1 = 1'b1; bus.wa1 = 5'd5; bus.wd1 = 32'h5555;
    bus.ra = {5'd0, 5'd5};
    #2 check("byp_rd0", 64'(bus.rd[31:0]), 64'h5555);
    check("nb_pre_rd0", 64'(bus_nb.rd[31:0]), 64'h0);
    step(); idle();
    #2 check("post_rd0", 64'(bus.rd[31:0]), 64'h5555);
    check("nb_post_rd0", 64'(bus_nb.rd[31:0]), 64'h5555);

    // Entry 0 ignores writes and marks
    step(); wr0(5'd0, 32'hFFFF_FFFF); mark(5'd0); bus.ra = {5'd0, 5'd0};
    #2 check("z_rd0", 64'(bus.rd[31:0]), 64'h0);
    check("z_rbusy0", 64'(bus.rbusy[0]), 64'h0);
    step(); idle();
    #2 check("z_cnt", 64'(bus.busy_cnt), 64'h0);
    check("z_rd0_post", 64'(bus.rd[31:0]), 64'h0);

    // Scoreboard marks and clears
    step(); mark(5'd7);
    step(); mark(5'd9);
    step(); idle(); bus.ra = {5'd9, 5'd7};
    #2 check("sb_cnt2", 64'(bus.busy_cnt), 64'd2);
    check("sb_rbusy7", 64'(bus.rbusy[0]), 64'd1);
    step(); wr0(5'd7, 32'h77); mark(5'd7);
    step(); idle();
    #2 check("sb_cnt_mark_wins", 64'(bus.busy_cnt), 64'd2);
    check("sb_rbusy7_set", 64'(bus.rbusy[0]), 64'd1);
    step(); wr0(5'd7, 32'h70); bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h90;
    step(); idle();
    #2 check("sb_cnt0", 64'(bus.busy_cnt), 64'd0);

    // Write to a busy entry forwards and hides busy
    step(); mark(5'd4);
    step(); idle(); wr0(5'd4, 32'h12); bus.ra = {5'd0, 5'd4};
    #2 check("fw_cnt1", 64'(bus.busy_cnt), 64'd1);
    check("fw_rbusy4", 64'(bus.rbusy[0]), 64'd0);
    check("fw_rd4", 64'(bus.rd[31:0]), 64'h12);
    step(); idle();
    #2 check("fw_cnt0", 64'(bus.busy_cnt), 64'd0);

    // Mid-cycle reset discards state and a pending write
    step(); mark(5'd10);
    step(); mark(5'd11);
    step(); mark(5'd12);
    step(); idle();
    #2 check("rst_pre_cnt", 64'(bus.busy_cnt), 64'd3);
    step(); wr0(5'd20, 32'h77); bus.ra = {5'd20, 5'd1};
    #2 rst_n = 1'b0;
    #1 check("rst_rd0", 64'(bus.rd[31:0]), 64'h0);
    check("rst_rd1", 64'(bus.rd[63:32]), 64'h0);
    check("rst_cnt", 64'(bus.busy_cnt), 64'h0);
    step();
    #2 rst_n = 1'b1; idle(); bus.ra = {5'd1, 5'd20};
    #1 check("rst_nowrite", 64'(bus.rd[31:0]), 64'h0);
    check("rst_cleared", 64'(bus.rd[63:32]), 64'h0);

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 1500; n++) begin
      step();
      bus.we0    = ($urandom_range(0, 2) == 0);
      bus.we1    = ($urandom_range(0, 2) == 0);
      bus.wa0    = rand_addr();
      bus.wa1    = ($urandom_range(0, 3) == 0) ? bus.wa0 : rand_addr();
      bus.wd0    = $urandom;
      bus.wd1    = $urandom;
      bus.mark_v = ($urandom_range(0, 1) == 0);
      bus.mark_a = ($urandom_range(0, 3) == 0) ? bus.wa0 : rand_addr();
      bus.ra     = {rand_addr(), rand_addr()};
      if ($urandom_range(0, 1) == 0) bus.ra[AW-1:0] = bus.wa1;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end
    step(); idle();
    step();
    #6;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
